// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath word, PC source select, branch kind and the
// redirect controller's state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_NPC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pcselect_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } brkind_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HALTED  = 2'd2
  } rstate_t;

endpackage

// File: rtl/pc_if.sv
// PC control bundle: the PC consumes it, the redirect controller produces it.
interface pc_if;
  import cpu_types_pkg::*;

  pcselect_t pc_select;
  word_t     jump_data;
  logic      enable;
  logic      z_fl;
  word_t     npc;
  word_t     rdat1;

  modport pc (
    input pc_select, jump_data, enable, z_fl, npc, rdat1
  );

  modport redirect (
    output pc_select, jump_data, enable, z_fl, npc, rdat1
  );
endinterface

// File: rtl/pc_target_gen.sv
// EX-stage redirect decode: picks JR > J > taken branch and computes its target.
module pc_target_gen
  import cpu_types_pkg::*;
(
  input  logic        ex_valid,
  input  logic [1:0]  ex_br,
  input  logic        ex_j,
  input  logic        ex_jr,
  input  word_t       ex_npc,
  input  word_t       ex_imm,
  input  logic [25:0] ex_jaddr,
  input  word_t       ex_rdat1,
  input  logic        ex_zero,
  output logic        redirect,
  output pcselect_t   select,
  output word_t       target
);

  logic branch_taken;

  assign branch_taken = ((ex_br == BR_EQ) && ex_zero) ||
                        ((ex_br == BR_NE) && !ex_zero);

  always_comb begin
    select = PC_NPC;
    target = '0;
    if (ex_valid) begin
      if (ex_jr) begin
        select = PC_JR;
        target = ex_rdat1;
      end else if (ex_j) begin
        select = PC_JUMP;
        target = {ex_npc[31:28], ex_jaddr, 2'b00};
      end else if (branch_taken) begin
        select = PC_BRANCH;
        // offset is in words; wraps silently at 32 bits
        target = ex_npc + (ex_imm << 2);
      end
    end
  end

  assign redirect = (select != PC_NPC);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Drives the PC control inputs from EX-stage control flow, holding a redirect
// until the PC can advance and freezing the PC after HALT.
module pc_redirect_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [1:0]       ex_br,
  input  logic             ex_j,
  input  logic             ex_jr,
  input  logic             ex_halt,
  input  logic [31:0]      ex_npc,
  input  logic [31:0]      ex_imm,
  input  logic [25:0]      ex_jaddr,
  input  logic [31:0]      ex_rdat1,
  input  logic             ex_zero,
  output pcselect_t        pc_select,
  output logic [31:0]      jump_data,
  output logic             enable,
  output logic             z_fl,
  output logic [31:0]      npc,
  output logic [31:0]      rdat1,
  output logic             flush,
  output logic [CNT_W-1:0] redirect_count
);

  rstate_t          state_reg, state_next;
  pcselect_t        pend_sel_reg, pend_sel_next;
  word_t            pend_tgt_reg, pend_tgt_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic      adv;
  logic      apply;
  logic      dec_redirect;
  pcselect_t dec_sel;
  word_t     dec_tgt;

  assign adv = ihit & ~stall;

  pc_target_gen u_target_gen (
    .ex_valid (ex_valid),
    .ex_br    (ex_br),
    .ex_j     (ex_j),
    .ex_jr    (ex_jr),
    .ex_npc   (ex_npc),
    .ex_imm   (ex_imm),
    .ex_jaddr (ex_jaddr),
    .ex_rdat1 (ex_rdat1),
    .ex_zero  (ex_zero),
    .redirect (dec_redirect),
    .select   (dec_sel),
    .target   (dec_tgt)
  );

  always_comb begin
    state_next    = state_reg;
    pend_sel_next = pend_sel_reg;
    pend_tgt_next = pend_tgt_reg;
    count_next    = count_reg;
    pc_select     = PC_NPC;
    jump_data     = '0;
    enable        = 1'b0;
    z_fl          = 1'b0;
    flush         = 1'b0;
    apply         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (ex_valid && ex_halt) begin
          state_next = ST_HALTED;
        end else if (dec_redirect) begin
          pc_select = dec_sel;
          jump_data = dec_tgt;
          z_fl      = (dec_sel == PC_BRANCH);
          enable    = adv;
          flush     = adv;
          apply     = adv;
          if (!adv) begin
            pend_sel_next = dec_sel;
            pend_tgt_next = dec_tgt;
            state_next    = ST_PENDING;
          end
        end else begin
          enable = adv;
        end
      end
      ST_PENDING: begin
        // pipeline is frozen, so EX inputs are stale and ignored here
        pc_select = pend_sel_reg;
        jump_data = pend_tgt_reg;
        z_fl      = (pend_sel_reg == PC_BRANCH);
        enable    = adv;
        flush     = adv;
        apply     = adv;
        if (adv) state_next = ST_IDLE;
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: state_next = ST_IDLE;
    endcase

    if (apply && (count_reg != {CNT_W{1'b1}})) count_next = count_reg + 1'b1;

    if (RST) begin
      pc_select = PC_NPC;
      jump_data = '0;
      enable    = 1'b0;
      z_fl      = 1'b0;
      flush     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      pend_sel_reg <= PC_NPC;
      pend_tgt_reg <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pend_sel_reg <= pend_sel_next;
      pend_tgt_reg <= pend_tgt_next;
      count_reg    <= count_next;
    end
  end

  assign npc            = ex_npc;
  assign rdat1          = (pc_select == PC_JR) ? jump_data : ex_rdat1;
  assign redirect_count = count_reg;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus a random
// run against a cycle-level reference model of the redirect rules.
module tb_pc_redirect_ctrl;
  import cpu_types_pkg::*;

  logic        clk, rst, ihit, stall, ex_valid, ex_j, ex_jr, ex_halt, ex_zero;
  logic [1:0]  ex_br;
  logic [31:0] ex_npc, ex_imm, ex_rdat1;
  logic [25:0] ex_jaddr;

  pcselect_t   pc_select;
  logic [31:0] jump_data, npc, rdat1;
  logic        enable, z_fl, flush;
  logic [15:0] redirect_count;

  pcselect_t   s_pc_select;
  logic [31:0] s_jump_data, s_npc, s_rdat1;
  logic        s_enable, s_z_fl, s_flush;
  logic [1:0]  s_count;

  int total = 0;
  int bad   = 0;

  // reference model state: 0 idle, 1 redirect waiting, 2 halted
  int          m_mode = 0;
  int          m_cnt  = 0;
  int          m_psel = 0;
  logic [31:0] m_ptgt = '0;

  logic [1:0]  e_sel;
  logic [31:0] e_jd, e_rdat1;
  logic        e_en, e_z, e_fl;
  int          e_cnt, e_cnt2;

  pc_redirect_ctrl #(.CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .stall(stall), .ex_valid(ex_valid),
    .ex_br(ex_br), .ex_j(ex_j), .ex_jr(ex_jr), .ex_halt(ex_halt),
    .ex_npc(ex_npc), .ex_imm(ex_imm), .ex_jaddr(ex_jaddr), .ex_rdat1(ex_rdat1),
    .ex_zero(ex_zero), .pc_select(pc_select), .jump_data(jump_data),
    .enable(enable), .z_fl(z_fl), .npc(npc), .rdat1(rdat1), .flush(flush),
    .redirect_count(redirect_count)
  );

  pc_redirect_ctrl #(.CNT_W(2)) dut_small (
    .CLK(clk), .RST(rst), .ihit(ihit), .stall(stall), .ex_valid(ex_valid),
    .ex_br(ex_br), .ex_j(ex_j), .ex_jr(ex_jr), .ex_halt(ex_halt),
    .ex_npc(ex_npc), .ex_imm(ex_imm), .ex_jaddr(ex_jaddr), .ex_rdat1(ex_rdat1),
    .ex_zero(ex_zero), .pc_select(s_pc_select), .jump_data(s_jump_data),
    .enable(s_enable), .z_fl(s_z_fl), .npc(s_npc), .rdat1(s_rdat1), .flush(s_flush),
    .redirect_count(s_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind: 0 none, 1 branch, 2 jump, 3 jr
  task automatic decode(output int kind, output logic [31:0] tgt);
    kind = 0;
    tgt  = '0;
    if (ex_valid) begin
      if (ex_jr) kind = 3;
      else if (ex_j) kind = 2;
      else if ((ex_br == 2'd1 && ex_zero) || (ex_br == 2'd2 && !ex_zero)) kind = 1;
    end
    case (kind)
      1: tgt = ex_npc + ex_imm * 4;
      2: tgt = {ex_npc[31:28], ex_jaddr, 2'b00};
      3: tgt = ex_rdat1;
      default: tgt = '0;
    endcase
  endtask

  task automatic model_expect();
    int k;
    logic [31:0] t;
    logic a;
    decode(k, t);
    a = ihit && !stall;
    e_sel = 2'd0; e_jd = '0; e_en = 1'b0; e_z = 1'b0; e_fl = 1'b0;
    if (rst || m_mode == 2) begin
      e_sel = 2'd0;
    end else if (m_mode == 1) begin
      e_sel = 2'(m_psel); e_jd = m_ptgt; e_z = (m_psel == 1); e_en = a; e_fl = a;
    end else if (ex_valid && ex_halt) begin
      e_sel = 2'd0;
    end else if (k != 0) begin
      e_sel = 2'(k); e_jd = t; e_z = (k == 1); e_en = a; e_fl = a;
    end else begin
      e_en = a;
    end
    e_rdat1 = (e_sel == 2'd3) ? e_jd : ex_rdat1;
    e_cnt   = (m_cnt > 65535) ? 65535 : m_cnt;
    e_cnt2  = (m_cnt > 3) ? 3 : m_cnt;
  endtask

  always @(posedge clk) begin
    int k;
    logic [31:0] t;
    decode(k, t);
    if (rst) begin
      m_mode = 0;
      m_cnt  = 0;
    end else if (m_mode == 0) begin
      if (ex_valid && ex_halt) m_mode = 2;
      else if (k != 0) begin
        if (ihit && !stall) m_cnt++;
        else begin
          m_mode = 1; m_psel = k; m_ptgt = t;
        end
      end
    end else if (m_mode == 1) begin
      if (ihit && !stall) begin
        m_cnt++;
        m_mode = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_br = 2'd0; ex_j = 0; ex_jr = 0; ex_halt = 0; ex_zero = 0;
    ex_npc = 32'h0; ex_imm = 32'h0; ex_jaddr = 26'h0; ex_rdat1 = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1; ihit = 1; stall = 0; clear_ex();
    ex_valid = 1; ex_j = 1; ex_jaddr = 26'h155;
    #3;
    total++;
    if (pc_select !== PC_NPC || enable !== 1'b0 || flush !== 1'b0 || z_fl !== 1'b0 || jump_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: sel=%0d en=%0b fl=%0b z=%0b jd=%h, need 0 0 0 0 0", pc_select, enable, flush, z_fl, jump_data);
    end
    next_cycle();
    rst = 0; clear_ex();
    #3;
    total++;
    if (redirect_count !== 16'd0 || enable !== 1'b1) begin
      bad++;
      $display("FAIL reset_count: count=%0d en=%0b, need 0 1", redirect_count, enable);
    end
    $display("reset: count=%0d en=%0b", redirect_count, enable);
    next_cycle();
  endtask

  task automatic test_beq_taken();
    clear_ex(); ihit = 1; stall = 0;
    ex_valid = 1; ex_br = 2'd1; ex_zero = 1; ex_npc = 32'h104; ex_imm = 32'hFFFF_FFFE;
    #3;
    total++;
    if (pc_select !== PC_BRANCH || jump_data !== 32'hFC || z_fl !== 1'b1 || enable !== 1'b1 || flush !== 1'b1) begin
      bad++;
      $display("FAIL beq_taken: sel=%0d jd=%h z=%0b en=%0b fl=%0b, need 1 000000fc 1 1 1", pc_select, jump_data, z_fl, enable, flush);
    end
    next_cycle();
    clear_ex();
    #3;
    total++;
    if (redirect_count !== 16'd1 || flush !== 1'b0) begin
      bad++;
      $display("FAIL beq_count: count=%0d fl=%0b, need 1 0", redirect_count, flush);
    end
    $display("beq_taken: jd=%h count=%0d", jump_data, redirect_count);
    next_cycle();
  endtask

  task automatic test_bne_not_taken();
    clear_ex(); ihit = 1; stall = 0;
    ex_valid = 1; ex_br = 2'd2; ex_zero = 1; ex_npc = 32'h2000;
    #3;
    total++;
    if (pc_select !== PC_NPC || flush !== 1'b0 || enable !== 1'b1 || npc !== 32'h2000) begin
      bad++;
      $display("FAIL bne_adv: sel=%0d fl=%0b en=%0b npc=%h, need 0 0 1 00002000", pc_select, flush, enable, npc);
    end
    next_cycle();
    ihit = 0;
    #3;
    total++;
    if (enable !== 1'b0 || flush !== 1'b0 || redirect_count !== 16'd1) begin
      bad++;
      $display("FAIL bne_noadv: en=%0b fl=%0b count=%0d, need 0 0 1", enable, flush, redirect_count);
    end
    $display("bne_not_taken: sel=%0d count=%0d", pc_select, redirect_count);
    next_cycle();
  endtask

  task automatic test_j_pending();
    clear_ex(); ihit = 0; stall = 0;
    ex_valid = 1; ex_j = 1; ex_npc = 32'h4000_0010; ex_jaddr = 26'h0000100;
    for (int i = 0; i < 3; i++) begin
      #3;
      total++;
      if (enable !== 1'b0 || flush !== 1'b0) begin
        bad++;
        $display("FAIL j_wait%0d: en=%0b fl=%0b, need 0 0", i, enable, flush);
      end
      next_cycle();
      clear_ex();
      ex_valid = 1; ex_jr = 1; ex_rdat1 = 32'hDEAD_BEEF;
    end
    ihit = 1;
    #3;
    total++;
    if (pc_select !== PC_JUMP || jump_data !== 32'h4000_0400 || enable !== 1'b1 || flush !== 1'b1 || z_fl !== 1'b0) begin
      bad++;
      $display("FAIL j_apply: sel=%0d jd=%h en=%0b fl=%0b z=%0b, need 2 40000400 1 1 0", pc_select, jump_data, enable, flush, z_fl);
    end
    next_cycle();
    clear_ex();
    #3;
    total++;
    if (flush !== 1'b0 || redirect_count !== 16'd2) begin
      bad++;
      $display("FAIL j_after: fl=%0b count=%0d, need 0 2", flush, redirect_count);
    end
    $display("j_pending: count=%0d", redirect_count);
    next_cycle();
  endtask

  task automatic test_jr_stall();
    clear_ex(); ihit = 1; stall = 1;
    ex_valid = 1; ex_jr = 1; ex_rdat1 = 32'h200;
    #3;
    total++;
    if (enable !== 1'b0 || flush !== 1'b0) begin
      bad++;
      $display("FAIL jr_stall: en=%0b fl=%0b, need 0 0", enable, flush);
    end
    next_cycle();
    ex_rdat1 = 32'h999;
    #3;
    total++;
    if (enable !== 1'b0 || jump_data !== 32'h200) begin
      bad++;
      $display("FAIL jr_hold: en=%0b jd=%h, need 0 00000200", enable, jump_data);
    end
    next_cycle();
    stall = 0;
    #3;
    total++;
    if (pc_select !== PC_JR || jump_data !== 32'h200 || rdat1 !== 32'h200 || flush !== 1'b1 || enable !== 1'b1) begin
      bad++;
      $display("FAIL jr_release: sel=%0d jd=%h rdat1=%h fl=%0b en=%0b, need 3 00000200 00000200 1 1", pc_select, jump_data, rdat1, flush, enable);
    end
    next_cycle();
    clear_ex();
    #3;
    total++;
    if (redirect_count !== 16'd3 || flush !== 1'b0) begin
      bad++;
      $display("FAIL jr_count: count=%0d fl=%0b, need 3 0", redirect_count, flush);
    end
    $display("jr_stall: jd=%h count=%0d", jump_data, redirect_count);
    next_cycle();
  endtask

  task automatic test_halt();
    clear_ex(); ihit = 1; stall = 0;
    ex_valid = 1; ex_halt = 1; ex_j = 1; ex_jaddr = 26'h3;
    #3;
    total++;
    if (enable !== 1'b0 || flush !== 1'b0 || pc_select !== PC_NPC) begin
      bad++;
      $display("FAIL halt_entry: en=%0b fl=%0b sel=%0d, need 0 0 0", enable, flush, pc_select);
    end
    next_cycle();
    ex_halt = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      total++;
      if (enable !== 1'b0 || flush !== 1'b0 || redirect_count !== 16'd3) begin
        bad++;
        $display("FAIL halt_hold%0d: en=%0b fl=%0b count=%0d, need 0 0 3", i, enable, flush, redirect_count);
      end
      next_cycle();
    end
    rst = 1;
    next_cycle();
    rst = 0; clear_ex();
    #3;
    total++;
    if (enable !== 1'b1 || redirect_count !== 16'd0) begin
      bad++;
      $display("FAIL halt_exit: en=%0b count=%0d, need 1 0", enable, redirect_count);
    end
    $display("halt: en=%0b count=%0d", enable, redirect_count);
    next_cycle();
  endtask

  task automatic test_reset_pending();
    clear_ex(); ihit = 0; stall = 0;
    ex_valid = 1; ex_j = 1; ex_jaddr = 26'h40;
    next_cycle();
    rst = 1; ihit = 1; clear_ex();
    #3;
    total++;
    if (flush !== 1'b0 || enable !== 1'b0) begin
      bad++;
      $display("FAIL rstpend_during: fl=%0b en=%0b, need 0 0", flush, enable);
    end
    next_cycle();
    rst = 0;
    #3;
    total++;
    if (flush !== 1'b0 || enable !== 1'b1 || pc_select !== PC_NPC || redirect_count !== 16'd0) begin
      bad++;
      $display("FAIL rstpend_after: fl=%0b en=%0b sel=%0d count=%0d, need 0 1 0 0", flush, enable, pc_select, redirect_count);
    end
    $display("reset_pending: fl=%0b sel=%0d", flush, pc_select);
    next_cycle();
  endtask

  task automatic test_saturation();
    int need_big[4]   = '{1, 2, 3, 4};
    int need_small[4] = '{1, 2, 3, 3};
    clear_ex(); ihit = 1; stall = 0;
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1; ex_br = 2'd2; ex_zero = 0; ex_npc = 32'h100 * (i + 1); ex_imm = 32'h4;
      next_cycle();
      clear_ex();
      #3;
      total++;
      if (int'(redirect_count) != need_big[i] || int'(s_count) != need_small[i]) begin
        bad++;
        $display("FAIL sat%0d: count=%0d small=%0d, need %0d %0d", i, redirect_count, s_count, need_big[i], need_small[i]);
      end
      $display("saturation %0d: count=%0d small=%0d", i, redirect_count, s_count);
    end
    next_cycle();
  endtask

  task automatic test_random();
    rst = 1; clear_ex();
    next_cycle();
    rst = 0;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 29) == 0);
      ihit     = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 3) == 0);
      ex_valid = ($urandom_range(0, 4) != 0);
      ex_br    = 2'($urandom_range(0, 3));
      ex_j     = ($urandom_range(0, 5) == 0);
      ex_jr    = ($urandom_range(0, 7) == 0);
      ex_halt  = ($urandom_range(0, 49) == 0);
      ex_zero  = 1'($urandom);
      ex_npc   = $urandom;
      ex_imm   = $urandom;
      ex_jaddr = 26'($urandom);
      ex_rdat1 = $urandom;
      #3;
      model_expect();
      total++;
      if (pc_select !== e_sel || jump_data !== e_jd || enable !== e_en || z_fl !== e_z || flush !== e_fl) begin
        bad++;
        $display("FAIL rnd%0d_ctrl: sel=%0d jd=%h en=%0b z=%0b fl=%0b, need %0d %h %0b %0b %0b",
                 i, pc_select, jump_data, enable, z_fl, flush, e_sel, e_jd, e_en, e_z, e_fl);
      end
      total++;
      if (rdat1 !== e_rdat1 || npc !== ex_npc || int'(redirect_count) != e_cnt || int'(s_count) != e_cnt2) begin
        bad++;
        $display("FAIL rnd%0d_data: rdat1=%h npc=%h count=%0d small=%0d, need %h %h %0d %0d",
                 i, rdat1, npc, redirect_count, s_count, e_rdat1, ex_npc, e_cnt, e_cnt2);
      end
      $display("rnd %0d: sel=%0d en=%0b fl=%0b count=%0d", i, pc_select, enable, flush, redirect_count);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1; ihit = 0; stall = 0; clear_ex();
    next_cycle();
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_j_pending();
    test_jr_stall();
    test_halt();
    test_reset_pending();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
